// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory responder.
// Holds the byte-lane enable constants, the trace entry width and field
// offsets, and the byte-lane merge helper used by the store path.
package dm_pkg;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // Trace entry layout: {pc, word address, merged data}
    localparam int TRC_ENTRY_W  = 96;
    localparam int TRC_DATA_LSB = 0;
    localparam int TRC_ADDR_LSB = 32;
    localparam int TRC_PC_LSB   = 64;

    // Replace each enabled byte lane of old_word with the matching lane of wdata.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  byteen);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// trace_fifo: first-word-fall-through FIFO for committed-store trace entries.
// Ports:
//   clk, reset (sync, active-low)
//   push, push_data : producer side; never back-pressured, excess is dropped
//   ready           : consumer accepts head entry
//   valid, head     : head entry (head is zero when empty)
//   count           : occupied entries
//   ovf             : sticky, an entry was dropped because the FIFO was full
module trace_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TRC_ENTRY_W = 96
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [TRC_ENTRY_W-1:0]        push_data,
    input  logic                          ready,
    output logic                          valid,
    output logic [TRC_ENTRY_W-1:0]        head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [TRC_ENTRY_W-1:0] slot_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W:0]         count_r;
    logic                   ovf_r;

    logic empty_s;
    logic full_s;
    logic pop_s;
    logic wr_s;
    logic drop_s;

    // Occupancy decode and push/pop qualification; a full FIFO still
    // accepts a push when the head leaves in the same cycle.
    always_comb begin
        empty_s = (count_r == {(PTR_W+1){1'b0}});
        full_s  = (count_r == CNT_FULL);
        pop_s   = !empty_s && ready;
        wr_s    = push && (!full_s || pop_s);
        drop_s  = push && full_s && !pop_s;
    end

    // Entry storage; slots need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            slot_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Fall-through head presentation.
    always_comb begin
        valid = !empty_s;
        count = count_r;
        ovf   = ovf_r;
        if (empty_s) begin
            head = {TRC_ENTRY_W{1'b0}};
        end else begin
            head = slot_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the CPU M-stage data bus.
// Word-organised RAM (2**ADDR_W x 32) with byte-enable writes, combinational
// reads, and a trace FIFO recording every committed store.
// Ports:
//   clk, reset (sync, active-low)
//   m_data_addr/m_data_wdata/m_data_byteen/m_inst_addr : CPU store/read request
//   m_data_rdata : combinational read of the addressed word (0 in reset)
//   trc_valid/trc_ready/trc_pc/trc_addr/trc_data : trace drain port (FWFT)
//   trc_count, trc_ovf : trace occupancy and sticky drop flag
// Optional: define DM_ADDR_CHECK_EN to add the sticky oob_err output and
// suppress out-of-range accesses instead of aliasing them into the RAM.
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 m_data_addr,
    input  logic [31:0]                 m_data_wdata,
    input  logic [3:0]                  m_data_byteen,
    input  logic [31:0]                 m_inst_addr,
    output logic [31:0]                 m_data_rdata,
    output logic                        trc_valid,
    input  logic                        trc_ready,
    output logic [31:0]                 trc_pc,
    output logic [31:0]                 trc_addr,
    output logic [31:0]                 trc_data,
    output logic [$clog2(FIFO_DEPTH):0] trc_count,
`ifdef DM_ADDR_CHECK_EN
    output logic                        trc_ovf,
    output logic                        oob_err
`else
    output logic                        trc_ovf
`endif
);

    localparam int WORDS = 2**ADDR_W;

    logic [31:0]            mem_r [WORDS];
    logic [ADDR_W-1:0]      idx_s;
    logic [31:0]            old_s;
    logic [31:0]            merged_s;
    logic                   oob_s;
    logic                   store_s;
    logic [TRC_ENTRY_W-1:0] entry_s;
    logic [TRC_ENTRY_W-1:0] head_s;
    logic                   unused_lane_s;

    // Byte-offset bits are irrelevant: the CPU delivers lane-aligned data.
    assign unused_lane_s = ^m_data_addr[1:0];

    // Address decode, range check and store qualification.
    always_comb begin
        idx_s    = m_data_addr[ADDR_W+1:2];
        old_s    = mem_r[idx_s];
        merged_s = merge_word(old_s, m_data_wdata, m_data_byteen);
`ifdef DM_ADDR_CHECK_EN
        oob_s    = |m_data_addr[31:ADDR_W+2];
`else
        oob_s    = 1'b0;
`endif
        store_s  = (m_data_byteen != BE_NONE) && reset && !oob_s;
        entry_s  = {m_inst_addr, m_data_addr[31:2], 2'b00, merged_s};
    end

    // RAM: cleared in reset, otherwise written with the merged word on a store.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (store_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    // Read path shows pre-store contents; blanked in reset and out of range.
    always_comb begin
        if (!reset || oob_s) begin
            m_data_rdata = 32'h0000_0000;
        end else begin
            m_data_rdata = old_s;
        end
    end

`ifdef DM_ADDR_CHECK_EN
    logic oob_err_r;

    // Sticky flag for a store that fell outside the RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            oob_err_r <= 1'b0;
        end else if (oob_s && (m_data_byteen != BE_NONE)) begin
            oob_err_r <= 1'b1;
        end
    end

    assign oob_err = oob_err_r;
`endif

    trace_fifo #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TRC_ENTRY_W (TRC_ENTRY_W)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (store_s),
        .push_data (entry_s),
        .ready     (trc_ready),
        .valid     (trc_valid),
        .head      (head_s),
        .count     (trc_count),
        .ovf       (trc_ovf)
    );

    // Split the head entry into its trace fields.
    always_comb begin
        trc_pc   = head_s[TRC_PC_LSB   +: 32];
        trc_addr = head_s[TRC_ADDR_LSB +: 32];
        trc_data = head_s[TRC_DATA_LSB +: 32];
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed and randomized bench for dm_responder with a
// behavioural memory/queue reference model.
module tb_dm_responder;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trc_valid;
    logic        trc_ready;
    logic [31:0] trc_pc;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;
    logic [3:0]  trc_count;
    logic        trc_ovf;
`ifdef DM_ADDR_CHECK_EN
    logic        oob_err;
`endif

    dm_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .trc_valid     (trc_valid),
        .trc_ready     (trc_ready),
        .trc_pc        (trc_pc),
        .trc_addr      (trc_addr),
        .trc_data      (trc_data),
        .trc_count     (trc_count),
`ifdef DM_ADDR_CHECK_EN
        .trc_ovf       (trc_ovf),
        .oob_err       (oob_err)
`else
        .trc_ovf       (trc_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [31:0] pc;
        bit [31:0] addr;
        bit [31:0] data;
    } ent_t;

    bit [31:0] mem_m [2**ADDR_W];
    ent_t      q_m [$];
    bit        ovf_m;
    bit        oob_m;
    bit        auto_en = 1'b0;
    int        checks = 0;
    int        failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_oob(input bit [31:0] a);
`ifdef DM_ADDR_CHECK_EN
        return (a >> (ADDR_W + 2)) != 32'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input bit [31:0] a);
        return int'((a >> 2) % (2**ADDR_W));
    endfunction

    // Reference behaviour for one rising edge, using the inputs now applied.
    task automatic model_edge();
        bit [31:0] w;
        ent_t e;
        if (!reset) begin
            foreach (mem_m[i]) mem_m[i] = 32'd0;
            q_m.delete();
            ovf_m = 1'b0;
            oob_m = 1'b0;
        end else begin
            if (q_m.size() > 0 && trc_ready) void'(q_m.pop_front());
            if (m_data_byteen != 4'd0 && is_oob(m_data_addr)) oob_m = 1'b1;
            if (m_data_byteen != 4'd0 && !is_oob(m_data_addr)) begin
                w = mem_m[widx(m_data_addr)];
                for (int i = 0; i < 4; i++)
                    if (m_data_byteen[i]) w[8*i +: 8] = m_data_wdata[8*i +: 8];
                mem_m[widx(m_data_addr)] = w;
                e.pc = m_inst_addr;
                e.addr = m_data_addr & 32'hFFFF_FFFC;
                e.data = w;
                if (q_m.size() < DEPTH) q_m.push_back(e);
                else ovf_m = 1'b1;
            end
        end
    endtask

    task automatic auto_checks();
        bit [31:0] er;
        er = (!reset || is_oob(m_data_addr)) ? 32'd0 : mem_m[widx(m_data_addr)];
        check("rdata", m_data_rdata, er);
        check("valid", {31'd0, trc_valid}, {31'd0, q_m.size() > 0});
        check("pc",    trc_pc,   q_m.size() > 0 ? q_m[0].pc   : 32'd0);
        check("taddr", trc_addr, q_m.size() > 0 ? q_m[0].addr : 32'd0);
        check("tdata", trc_data, q_m.size() > 0 ? q_m[0].data : 32'd0);
        check("count", {28'd0, trc_count}, 32'(q_m.size()));
        check("ovf",   {31'd0, trc_ovf}, {31'd0, ovf_m});
`ifdef DM_ADDR_CHECK_EN
        check("oob",   {31'd0, oob_err}, {31'd0, oob_m});
`endif
    endtask

    // One clock: check combinational view at negedge, then advance the model.
    task automatic cycle();
        @(negedge clk);
        if (auto_en) auto_checks();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drv(input logic rst, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] pc, input logic rdy);
        reset = rst;
        m_data_addr = a;
        m_data_wdata = d;
        m_data_byteen = be;
        m_inst_addr = pc;
        trc_ready = rdy;
    endtask

    task automatic do_reset();
        drv(1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0);
        cycle();
        cycle();
    endtask

    initial begin
        do_reset();
        auto_en = 1'b1;

        // 1: word store then read back and inspect the trace head.
        drv(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h3000, 1'b0);
        cycle();
        drv(1'b1, 32'h10, 32'd0, 4'b0000, 32'd0, 1'b0);
        #1;
        check("t1_rdata", m_data_rdata, 32'hDEADBEEF);
        check("t1_valid", {31'd0, trc_valid}, 32'd1);
        check("t1_pc",    trc_pc, 32'h3000);
        check("t1_addr",  trc_addr, 32'h10);
        check("t1_data",  trc_data, 32'hDEADBEEF);
        check("t1_count", {28'd0, trc_count}, 32'd1);

        // 2: byte store merges into an existing word; same-cycle read is old.
        drv(1'b1, 32'h10, 32'h11223344, 4'b1111, 32'h3004, 1'b1);
        cycle();
        drv(1'b1, 32'h12, 32'h00AB0000, 4'b0100, 32'h3008, 1'b1);
        #1;
        check("t2_old", m_data_rdata, 32'h11223344);
        cycle();
        drv(1'b1, 32'h10, 32'd0, 4'b0000, 32'd0, 1'b0);
        #1;
        check("t2_new", m_data_rdata, 32'h11AB3344);

        // 3: overflow with nine stores and no drain, then drain in order.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drv(1'b1, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'b1111, 32'h4000 + 32'(4*i), 1'b0);
            cycle();
        end
        drv(1'b1, 32'h120, 32'd0, 4'b0000, 32'd0, 1'b0);
        #1;
        check("t3_count", {28'd0, trc_count}, 32'd8);
        check("t3_ovf",   {31'd0, trc_ovf}, 32'd1);
        check("t3_ninth", m_data_rdata, 32'hA000_0008);
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 32'h0, 32'd0, 4'b0000, 32'd0, 1'b1);
            #1;
            check("t3_order", trc_data, 32'hA000_0000 + 32'(i));
            cycle();
        end

        // 4: full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 32'h200 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'b1111, 32'h5000, 1'b0);
            cycle();
        end
        drv(1'b1, 32'h240, 32'hB000_00FF, 4'b1111, 32'h5040, 1'b1);
        cycle();
        drv(1'b1, 32'h0, 32'd0, 4'b0000, 32'd0, 1'b0);
        #1;
        check("t4_count", {28'd0, trc_count}, 32'd8);
        check("t4_ovf",   {31'd0, trc_ovf}, 32'd0);
        check("t4_head",  trc_data, 32'hB000_0001);
        check("t4_tail",  q_m[7].data, 32'hB000_00FF);

        // 5: reset during a store with three queued entries.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'h300 + 32'(4*i), 32'hC000_0000, 4'b1111, 32'h6000, 1'b0);
            cycle();
        end
        drv(1'b0, 32'h380, 32'h12345678, 4'b1111, 32'h6100, 1'b0);
        cycle();
        drv(1'b1, 32'h380, 32'd0, 4'b0000, 32'd0, 1'b0);
        #1;
        check("t5_word",  m_data_rdata, 32'd0);
        check("t5_count", {28'd0, trc_count}, 32'd0);
        check("t5_valid", {31'd0, trc_valid}, 32'd0);
        check("t5_ovf",   {31'd0, trc_ovf}, 32'd0);

`ifdef DM_ADDR_CHECK_EN
        // 6: out-of-range store is suppressed and flagged.
        drv(1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 4'b1111, 32'h7000, 1'b0);
        #1;
        check("t6_rdata", m_data_rdata, 32'd0);
        cycle();
        drv(1'b1, 32'h0, 32'd0, 4'b0000, 32'd0, 1'b0);
        #1;
        check("t6_oob",   {31'd0, oob_err}, 32'd1);
        check("t6_word0", m_data_rdata, 32'd0);
        check("t6_count", {28'd0, trc_count}, 32'd0);
`endif

        // Randomized traffic over a small word set, with aliasing upper bits.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [3:0]  be;
            a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_C000);
            be = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            drv(($urandom_range(0, 60) != 0), a, $urandom, be, $urandom, 1'($urandom));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the pipelined CPU's M-stage data bus: word-organised RAM with byte-enable writes and combinational reads.
- Records every committed store into a write-trace FIFO, drained by the bench over a valid/ready port.
- The CPU cannot stall on stores, so trace overflow is flagged rather than back-pressured.
- Sits outside the CPU top, wired to m_data_addr/m_data_wdata/m_data_byteen/m_inst_addr/m_data_rdata.

Parameters:
- ADDR_W, 12: word-address width; RAM holds 2**ADDR_W 32-bit words.
- FIFO_DEPTH, 8: trace entries; must be a power of two and at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset). The CPU side uses active-high, so integration inverts it.
- m_data_addr  in  32  byte address from CPU M stage
- m_data_wdata  in  32  lane-aligned store data
- m_data_byteen  in  4  byte-lane write enables; 4'b0000 = no store
- m_inst_addr  in  32  PC of the M-stage instruction
- m_data_rdata  out  32  combinational read of word m_data_addr[ADDR_W+1:2]
- trc_valid  out  1  head trace entry present
- trc_ready  in  1  bench accepts head entry
- trc_pc  out  32  head entry PC
- trc_addr  out  32  head entry word-aligned address, bits [1:0] = 0
- trc_data  out  32  head entry merged word after the store
- trc_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- trc_ovf  out  1  sticky: a trace entry was dropped

Behaviour:
- Read path:
  - m_data_rdata = mem[m_data_addr[ADDR_W+1:2]], purely combinational.
  - Returns the pre-store contents in the same cycle as a store to that word; the new contents appear from the next cycle.
  - Forced to 0 while reset=0.
- Store:
  - A store occurs when byteen != 0 and reset=1.
  - Merged word = old word with lane i replaced by wdata[8i+7:8i] for each set byteen[i].
  - The merged word is written to RAM at the rising edge.
  - Address bits [1:0] are ignored; the CPU already lane-aligns data.
- Trace push: every store pushes {m_inst_addr, {m_data_addr[31:2],2'b00}, merged word}.
- FIFO:
  - First-word-fall-through: trc_* outputs show the head entry combinationally and are 0 when empty.
  - Pop occurs when trc_valid & trc_ready.
  - Push and pop are evaluated in the same cycle:
    - Empty, push and ready: entry stored; no pop, since trc_valid=0. trc_valid becomes 1 next cycle.
    - Full, push and pop: both happen; trc_count stays FIFO_DEPTH.
    - Full, push without pop: entry dropped, trc_ovf <= 1. The RAM write still happens.
  - Pointers wrap modulo FIFO_DEPTH.
  - trc_count updates at the edge: +1 on push only, -1 on pop only, unchanged on both or neither.
  - trc_ovf stays 1 until reset.
- Reset (reset=0 at a rising edge), including mid-operation:
  - All RAM words <= 0.
  - FIFO pointers, trc_count and trc_ovf <= 0, so trc_valid=0.
  - Any store presented in that cycle is discarded, both RAM write and push.
- Latency:
  - Store-to-RAM: 1 cycle.
  - Store-to-trc_valid when empty: 1 cycle.
  - Read: 0 cycles.

Optional Feature:
- Macro: DM_ADDR_CHECK_EN.
- When defined:
  - Adds output port oob_err (1 bit, sticky, reset 0).
  - An access is out of range if any of m_data_addr[31:ADDR_W+2] is nonzero.
  - Out-of-range store: suppressed (no RAM write, no trace push) and oob_err <= 1.
  - Out-of-range read: m_data_rdata = 0 (no oob_err set for reads).
- When undefined: no oob_err port; the upper address bits are ignored and addresses alias into the RAM.

Decomposition:
- Package dm_pkg holds:
  - byte-lane constants: BE_NONE=4'b0000, BE_WORD=4'b1111, BE_HALF_LO=4'b0011, BE_HALF_HI=4'b1100;
  - TRC_ENTRY_W = 96;
  - the trace entry field offsets.
- Sub-module trace_fifo:
  - parameterised by FIFO_DEPTH and TRC_ENTRY_W;
  - push/pop/full/empty/count/ovf logic with FWFT output;
  - dm_responder instantiates it next to the RAM and merge logic.

Test Plan:
1. Reset, then word store: addr 0x0000_0010, wdata 0xDEADBEEF, be 4'b1111, pc 0x3000 → next cycle rdata at 0x10 = 0xDEADBEEF, trc_valid=1, trc_pc=0x3000, trc_addr=0x10, trc_data=0xDEADBEEF, trc_count=1.
2. Byte store into word 0x11223344: addr 0x12, wdata 0x00AB0000, be 4'b0100 → word = 0x11AB3344. In the same cycle rdata still reads 0x11223344.
3. With trc_ready=0, 9 stores at FIFO_DEPTH=8 → trc_count=8, trc_ovf=1. All 9 RAM words updated; popping yields entries 1–8 in order.
4. FIFO full, store with trc_ready=1 in the same cycle → trc_count stays 8, trc_ovf stays 0, new entry lands at the tail.
5. Reset asserted (0) during a store cycle with FIFO count 3 → RAM word unchanged (0), trc_count=0, trc_valid=0, trc_ovf=0.
6. With DM_ADDR_CHECK_EN defined, store to 0x0001_0000 at ADDR_W=12 → oob_err=1, no trace push, word 0 unchanged, rdata=0 for that address.
